// File: rtl/mips_alu_pkg.sv
// Shared ALU issue encodings: alu_op codes, MIPS opcode/funct values, decoded entry.
// No logic; pure constants and types.
// Used by alu_decode and alu_issue.
package mips_alu_pkg;

  localparam logic [4:0] ALU_SLL  = 5'b00000;
  localparam logic [4:0] ALU_SRL  = 5'b00010;
  localparam logic [4:0] ALU_SRA  = 5'b00011;
  localparam logic [4:0] ALU_SLLV = 5'b00100;
  localparam logic [4:0] ALU_SRLV = 5'b00110;
  localparam logic [4:0] ALU_SRAV = 5'b00111;
  localparam logic [4:0] ALU_JAL  = 5'b01000;
  localparam logic [4:0] ALU_ADD  = 5'b10000;
  localparam logic [4:0] ALU_ADDU = 5'b10001;
  localparam logic [4:0] ALU_SUB  = 5'b10010;
  localparam logic [4:0] ALU_SUBU = 5'b10011;
  localparam logic [4:0] ALU_AND  = 5'b10100;
  localparam logic [4:0] ALU_OR   = 5'b10101;
  localparam logic [4:0] ALU_XOR  = 5'b10110;
  localparam logic [4:0] ALU_NOR  = 5'b10111;
  localparam logic [4:0] ALU_LUI  = 5'b11000;
  localparam logic [4:0] ALU_SLT  = 5'b11010;
  localparam logic [4:0] ALU_SLTU = 5'b11011;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_SLLV = 6'b000100;
  localparam logic [5:0] F_SRLV = 6'b000110;
  localparam logic [5:0] F_SRAV = 6'b000111;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLTU = 6'b101011;

  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  wr_reg;
    logic        illegal;
  } issue_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational MIPS ALU instruction decode into op/a/b/wr_reg/illegal.
// Latency: zero (pure combinational).
// Backpressure: none; the issue stage owns all flow control.
module alu_decode
  import mips_alu_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [4:0]  op,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [4:0]  wr_reg,
  output logic        illegal
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [31:0] shamt_ext;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
  logic        unused_rs_field;

  assign opcode          = instr[31:26];
  assign funct           = instr[5:0];
  assign imm             = instr[15:0];
  assign shamt_ext       = {27'b0, instr[10:6]};
  assign imm_sext        = {{16{imm[15]}}, imm};
  assign imm_zext        = {16'b0, imm};
  // Source register index is resolved upstream; only its value arrives here.
  assign unused_rs_field = ^instr[25:21];

  always_comb begin
    op      = ALU_SLL;
    a       = '0;
    b       = '0;
    wr_reg  = '0;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        a      = rs_val;
        b      = rt_val;
        wr_reg = instr[15:11];
        case (funct)
          F_SLL:  begin op = ALU_SLL; a = shamt_ext; end
          F_SRL:  begin op = ALU_SRL; a = shamt_ext; end
          F_SRA:  begin op = ALU_SRA; a = shamt_ext; end
          F_SLLV: op = ALU_SLLV;
          F_SRLV: op = ALU_SRLV;
          F_SRAV: op = ALU_SRAV;
          F_ADD:  op = ALU_ADD;
          F_ADDU: op = ALU_ADDU;
          F_SUB:  op = ALU_SUB;
          F_SUBU: op = ALU_SUBU;
          F_AND:  op = ALU_AND;
          F_OR:   op = ALU_OR;
          F_XOR:  op = ALU_XOR;
          F_NOR:  op = ALU_NOR;
          F_SLT:  op = ALU_SLT;
          F_SLTU: op = ALU_SLTU;
          default: illegal = 1'b1;
        endcase
      end
      OP_ADDI:  begin op = ALU_ADD;  a = rs_val; b = imm_sext; wr_reg = instr[20:16]; end
      OP_ADDIU: begin op = ALU_ADDU; a = rs_val; b = imm_sext; wr_reg = instr[20:16]; end
      OP_SLTI:  begin op = ALU_SLT;  a = rs_val; b = imm_sext; wr_reg = instr[20:16]; end
      OP_SLTIU: begin op = ALU_SLTU; a = rs_val; b = imm_sext; wr_reg = instr[20:16]; end
      OP_ANDI:  begin op = ALU_AND;  a = rs_val; b = imm_zext; wr_reg = instr[20:16]; end
      OP_ORI:   begin op = ALU_OR;   a = rs_val; b = imm_zext; wr_reg = instr[20:16]; end
      OP_XORI:  begin op = ALU_XOR;  a = rs_val; b = imm_zext; wr_reg = instr[20:16]; end
      OP_LUI:   begin op = ALU_LUI;  b = imm_zext; wr_reg = instr[20:16]; end
      OP_JAL:   begin op = ALU_JAL;  a = pc + 32'd8; wr_reg = 5'd31; end
      default:  illegal = 1'b1;
    endcase
    // Illegal entries travel downstream with every payload field zeroed.
    if (illegal) begin
      op     = ALU_SLL;
      a      = '0;
      b      = '0;
      wr_reg = '0;
    end
  end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: registers decoded entries; ALU_ISSUE_SKID_BUF_EN adds a skid entry.
// Latency: one cycle from accept to out_valid.
// Backpressure: in_ready = !out_valid || out_ready, or registered skid-empty with the macro.
module alu_issue
  import mips_alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  wr_reg,
  output logic        illegal
);

  logic [4:0]  dec_op;
  logic [31:0] dec_a;
  logic [31:0] dec_b;
  logic [4:0]  dec_wr_reg;
  logic        dec_illegal;
  issue_t      dec;
  issue_t      main_q;
  logic        main_vld;
  logic        accept;
  logic        drain;

  alu_decode u_decode (
    .instr   (instr),
    .pc      (pc),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .op      (dec_op),
    .a       (dec_a),
    .b       (dec_b),
    .wr_reg  (dec_wr_reg),
    .illegal (dec_illegal)
  );

  assign dec    = '{op: dec_op, a: dec_a, b: dec_b, wr_reg: dec_wr_reg, illegal: dec_illegal};
  assign drain  = main_vld && out_ready;
  // A flush drops the incoming beat even though in_ready was shown.
  assign accept = in_valid && in_ready && !flush;

`ifdef ALU_ISSUE_SKID_BUF_EN
  issue_t skid_q;
  logic   skid_vld;

  assign in_ready = !skid_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q   <= '0;
      main_vld <= 1'b0;
      skid_q   <= '0;
      skid_vld <= 1'b0;
    end else if (flush) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
    end else if (skid_vld) begin
      if (drain) begin
        main_q   <= skid_q;
        skid_vld <= 1'b0;
      end
    end else if (accept) begin
      if (!main_vld || drain) begin
        main_q   <= dec;
        main_vld <= 1'b1;
      end else begin
        skid_q   <= dec;
        skid_vld <= 1'b1;
      end
    end else if (drain) begin
      main_vld <= 1'b0;
    end
  end
`else
  assign in_ready = !main_vld || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q   <= '0;
      main_vld <= 1'b0;
    end else if (flush) begin
      main_vld <= 1'b0;
    end else if (accept) begin
      main_q   <= dec;
      main_vld <= 1'b1;
    end else if (drain) begin
      main_vld <= 1'b0;
    end
  end
`endif

  assign out_valid = main_vld;
  assign alu_op    = main_q.op;
  assign alu_a     = main_q.a;
  assign alu_b     = main_q.b;
  assign wr_reg    = main_q.wr_reg;
  assign illegal   = main_q.illegal;

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have parameter: none; all encodings are fixed constants.
REQ-002 SHALL have ports: clk  in  1  rising-edge clock.
REQ-003 SHALL have: rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have: in_valid  in  1, in_ready  out  1  (upstream handshake); instr  in  32; pc  in  32; rs_val  in  32; rt_val  in  32.
REQ-005 SHALL have: flush  in  1  synchronous squash of all held entries.
REQ-006 SHALL have: out_valid  out  1, out_ready  in  1  (downstream handshake).
REQ-007 SHALL have: alu_op  out  5  ALU operation code; alu_a  out  32; alu_b  out  32; wr_reg  out  5  destination register; illegal  out  1  unsupported instruction.

Function
REQ-008 SHALL decode instr and register alu_op/alu_a/alu_b/wr_reg/illegal; latency one cycle from accepted input to out_valid.
REQ-009 SHALL accept an input when in_valid && in_ready; SHALL present an entry until out_valid && out_ready; held outputs SHALL stay stable while out_valid && !out_ready.
REQ-010 R-type (opcode 0) funct->alu_op: 100000->10000, 100001->10001, 100010->10010, 100011->10011, 100100->10100, 100101->10101, 100110->10110, 100111->10111, 101010->11010, 101011->11011; alu_a=rs_val, alu_b=rt_val, wr_reg=instr[15:11].
REQ-011 Shifts: sll 000000->00000, srl 000010->00010, sra 000011->00011 with alu_a={27'b0,instr[10:6]}; sllv 000100->00100, srlv 000110->00110, srav 000111->00111 with alu_a=rs_val; alu_b=rt_val, wr_reg=instr[15:11].
REQ-012 I-type, alu_a=rs_val, wr_reg=instr[20:16]: addi->10000, addiu->10001, slti->11010, sltiu->11011 with alu_b sign-extended imm; andi->10100, ori->10101, xori->10110 with alu_b zero-extended imm.
REQ-013 lui (001111) SHALL give alu_op=11000, alu_b={16'b0,imm}, alu_a=0, wr_reg=instr[20:16].
REQ-014 jal (000011) SHALL give alu_op=01000, alu_a=pc+8 (mod 2^32), alu_b=0, wr_reg=31.
REQ-015 Any other opcode/funct SHALL give illegal=1, alu_op=00000, alu_a=alu_b=0, wr_reg=0; entry still flows through the handshake.
REQ-016 flush SHALL clear out_valid and all buffered entries next edge; flush wins over a simultaneous accept (input dropped, not stored).
REQ-017 Simultaneous accept and drain on a full single stage SHALL replace the entry with no bubble.

Reset
REQ-018 rst SHALL asynchronously force out_valid=0, alu_op=0, alu_a=0, alu_b=0, wr_reg=0, illegal=0, all buffer valid bits 0; in_ready SHALL be 1 after release.
REQ-019 rst mid-transfer SHALL discard all held entries; no output after release until a new accept.

Configuration
REQ-020 Macro ALU_ISSUE_SKID_BUF_EN defined: SHALL add a one-entry skid buffer; in_ready SHALL be a registered signal = skid empty, independent of same-cycle out_ready; capacity two entries, order preserved.
REQ-021 Macro undefined: single register stage; in_ready = !out_valid || out_ready (combinational); capacity one entry.

Structure
REQ-022 Package mips_alu_pkg SHALL hold the 5-bit alu_op constants, opcode/funct constants and the decoded-entry struct typedef (op, a, b, wr_reg, illegal).
REQ-023 Combinational decoding SHALL live in sub-module alu_decode; alu_issue holds handshake, buffer and registers only.

Verification
REQ-024 addu $3,$1,$2 (instr 0x00221821), rs_val=5, rt_val=7 -> one cycle later out_valid=1, alu_op=10001, a=5, b=7, wr_reg=3.
REQ-025 sra $4,$5,3 (0x000520C3), rt_val=0x80000000 -> alu_op=00011, alu_a=3, alu_b=0x80000000, wr_reg=4.
REQ-026 addi $2,$1,-1 (0x2022FFFF) -> alu_b=0xFFFFFFFF, op=10000; ori $2,$1,0xFFFF -> alu_b=0x0000FFFF, op=10101; jal at pc=0x00400000 -> op=01000, a=0x00400008, wr_reg=31.
REQ-027 out_ready=0 for 5 cycles with in_valid=1 -> outputs stable, exactly 1 (macro off) or 2 (macro on) entries accepted, then drained in order with no loss or duplication.
REQ-028 flush asserted with in_valid=1 and entries held -> next cycle out_valid=0, that input never appears; rst pulse mid-stream -> out_valid=0 immediately, in_ready=1 after release.
REQ-029 instr 0xFC000000 -> illegal=1, alu_op=0, a=b=0, wr_reg=0, out_valid=1.
